// File: rtl/authentication_ctrl.sv
// Account/PIN lookup against a fixed 10-entry ROM, with a registered match result,
// a count of failed login attempts and a sticky lockout flag.
module authentication_ctrl #(
    parameter int NUM_ACCTS = 10,
    parameter int ACC_W     = 12,
    parameter int PIN_W     = 4,
    parameter int IDX_W     = 4,
    parameter int MAX_FAILS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ACC_W-1:0] acc_number,
    input  logic [PIN_W-1:0] pin,
    input  logic             action,
    input  logic             de_auth,
    output logic             was_successful,
    output logic [IDX_W-1:0] acc_index,
    output logic             exit_on_three_failures
);

    // Account numbers are decimal values reduced to ACC_W bits.
    localparam logic [ACC_W-1:0] ACCT [10] = '{
        ACC_W'(32'd1234), ACC_W'(32'd5673), ACC_W'(32'd3487), ACC_W'(32'd2352),
        ACC_W'(32'd9999), ACC_W'(32'd3546), ACC_W'(32'd7896), ACC_W'(32'd6688),
        ACC_W'(32'd6776), ACC_W'(32'd1356)
    };
    localparam logic [PIN_W-1:0] PINS [10] = '{
        PIN_W'(4'b0000), PIN_W'(4'b0001), PIN_W'(4'b0010), PIN_W'(4'b1111),
        PIN_W'(4'b1100), PIN_W'(4'b0101), PIN_W'(4'b0110), PIN_W'(4'b0111),
        PIN_W'(4'b1011), PIN_W'(4'b1001)
    };
    localparam logic [2:0] MAX_CNT = 3'(MAX_FAILS);

    logic             succ_q, succ_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lock_q, lock_d;
    logic [2:0]       fail_cnt_q, fail_cnt_d;
    logic             de_auth_q;

    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic             lock_eff;
    logic             rise;

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        // Ascending scan: the highest matching index overwrites earlier ones.
        for (int unsigned i = 0; i < 32'(NUM_ACCTS); i++) begin
            if (acc_number == ACCT[i] && (!action || pin == PINS[i])) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        lock_eff   = lock_q & action;
        succ_d     = hit_any & ~de_auth & ~lock_eff;
        idx_d      = succ_d ? hit_idx : '0;
        rise       = de_auth & ~de_auth_q;
        fail_cnt_d = fail_cnt_q;
        if (rise && action) begin
            if (succ_q)
                fail_cnt_d = '0;
            else if (fail_cnt_q < MAX_CNT)
                fail_cnt_d = fail_cnt_q + 3'd1;
        end
        lock_d = lock_q | (fail_cnt_d == MAX_CNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            succ_q     <= 1'b0;
            idx_q      <= '0;
            lock_q     <= 1'b0;
            fail_cnt_q <= '0;
            de_auth_q  <= 1'b0;
        end else begin
            succ_q     <= succ_d;
            idx_q      <= idx_d;
            lock_q     <= lock_d;
            fail_cnt_q <= fail_cnt_d;
            de_auth_q  <= de_auth;
        end
    end

    assign was_successful         = succ_q;
    assign acc_index              = idx_q;
    assign exit_on_three_failures = lock_q;

endmodule

// File: tb/tb_authentication_ctrl.sv
// Scoreboard bench for authentication_ctrl: directed vectors push expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_authentication_ctrl;

    localparam int ACC_W = 12;
    localparam int PIN_W = 4;
    localparam int IDX_W = 4;

    typedef struct {
        logic             succ;
        logic [IDX_W-1:0] idx;
        logic             lock;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [ACC_W-1:0] acc_number = '0;
    logic [PIN_W-1:0] pin = '0;
    logic             action = 1'b0;
    logic             de_auth = 1'b0;
    logic             was_successful;
    logic [IDX_W-1:0] acc_index;
    logic             exit_on_three_failures;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    authentication_ctrl #(
        .NUM_ACCTS(10), .ACC_W(ACC_W), .PIN_W(PIN_W), .IDX_W(IDX_W), .MAX_FAILS(3)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .acc_number            (acc_number),
        .pin                   (pin),
        .action                (action),
        .de_auth               (de_auth),
        .was_successful        (was_successful),
        .acc_index             (acc_index),
        .exit_on_three_failures(exit_on_three_failures)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input int a, input int p, input bit act, input bit da,
                        input bit es, input int ei, input bit el);
        exp_t e;
        @(negedge clk);
        acc_number = ACC_W'(a);
        pin        = PIN_W'(p);
        action     = act;
        de_auth    = da;
        e.succ = es;
        e.idx  = IDX_W'(ei);
        e.lock = el;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("was_successful", int'(was_successful), int'(e.succ));
                check("acc_index", int'(acc_index), int'(e.idx));
                check("lockout", int'(exit_on_three_failures), int'(e.lock));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #12;
        check("reset_succ", int'(was_successful), 0);
        check("reset_idx", int'(acc_index), 0);
        check("reset_lock", int'(exit_on_three_failures), 0);
        @(negedge clk);
        reset = 1'b1;

        // AUTH good credentials
        step(1234, 4'b0000, 1, 0, 1, 0, 0);
        step(9999, 4'b1100, 1, 0, 1, 4, 0);
        // AUTH bad PIN, unknown account
        step(5673, 4'b0000, 1, 0, 0, 0, 0);
        step(4321, 4'b0000, 1, 0, 0, 0, 0);
        // FIND ignores PIN
        step(3487, 4'b1111, 0, 0, 1, 2, 0);
        step(1356, 4'b0000, 0, 0, 1, 9, 0);
        step(0,    4'b0000, 0, 0, 0, 0, 0);
        // FIND-mode de_auth pulse must not count as a failure
        step(0,    4'b0000, 0, 1, 0, 0, 0);
        step(0,    4'b0000, 0, 0, 0, 0, 0);
        // de_auth forces outputs low; success on rise clears the counter
        step(1234, 4'b0000, 1, 0, 1, 0, 0);
        step(1234, 4'b0000, 1, 1, 0, 0, 0);
        step(1234, 4'b0000, 1, 0, 1, 0, 0);
        // three failed AUTH attempts
        step(5673, 4'b0000, 1, 0, 0, 0, 0);
        step(5673, 4'b0000, 1, 1, 0, 0, 0);
        step(5673, 4'b0000, 1, 0, 0, 0, 0);
        step(5673, 4'b0000, 1, 1, 0, 0, 0);
        step(5673, 4'b0000, 1, 0, 0, 0, 0);
        step(5673, 4'b0000, 1, 1, 0, 0, 1);
        // locked: AUTH blocked, FIND allowed, sticky across a successful close
        step(1234, 4'b0000, 1, 0, 0, 0, 1);
        step(3487, 4'b0000, 0, 0, 1, 2, 1);
        step(1234, 4'b0000, 1, 1, 0, 0, 1);
        step(1234, 4'b0000, 1, 0, 0, 0, 1);

        // asynchronous reset mid-run
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_succ", int'(was_successful), 0);
        check("async_rst_idx", int'(acc_index), 0);
        check("async_rst_lock", int'(exit_on_three_failures), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1234, 4'b0000, 1, 0, 1, 0, 0);
        step(6776, 4'b1011, 1, 0, 1, 8, 0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
